// File: rtl/bram_rd_checker_if.sv
// Read-back stream and status bundle between the BRAM test driver and bram_rd_checker.
// BRAM_CHK_SUM_EN adds the o_sum running-sum output.
interface bram_rd_checker_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
);
  logic                  i_run;
  logic [ADDR_WIDTH-1:0] i_cnt;
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_done;
  logic                  o_idle;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_pass;
  logic                  o_short;
  logic [ADDR_WIDTH-1:0] o_rx_cnt;
  logic [ADDR_WIDTH-1:0] o_err_cnt;
  logic [ADDR_WIDTH-1:0] o_first_err_idx;
`ifdef BRAM_CHK_SUM_EN
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] o_sum;
`endif

  modport master (
    output i_run, i_cnt, i_valid, i_data, i_done,
    input  o_idle, o_busy, o_done, o_pass, o_short,
    input  o_rx_cnt, o_err_cnt, o_first_err_idx
`ifdef BRAM_CHK_SUM_EN
    , input o_sum
`endif
  );

  modport slave (
    input  i_run, i_cnt, i_valid, i_data, i_done,
    output o_idle, o_busy, o_done, o_pass, o_short,
    output o_rx_cnt, o_err_cnt, o_first_err_idx
`ifdef BRAM_CHK_SUM_EN
    , output o_sum
`endif
  );
endinterface

// File: rtl/bram_rd_checker.sv
// Checks the BRAM read-back stream against a mod-MOD counter pattern and reports a verdict.
// Define BRAM_CHK_SUM_EN to add the o_sum running sum of accepted words.
module bram_rd_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int MOD        = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_rd_checker_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] EXP_LAST = DATA_WIDTH'(MOD - 1);
  localparam logic [ADDR_WIDTH-1:0] ALL_ONES = '1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] rx_cnt, rx_nxt;
  logic [ADDR_WIDTH-1:0] err_cnt, err_nxt;
  logic [ADDR_WIDTH-1:0] first_err_idx;
  logic [DATA_WIDTH-1:0] exp_val;
  logic                  short_r;
  logic                  pass_r;
  logic                  start, accept, mismatch, reach, end_short;

  always_comb begin
    start     = (state == IDLE) && bus.i_run;
    accept    = (state == CHECK) && bus.i_valid;
    mismatch  = accept && (bus.i_data != exp_val);
    rx_nxt    = accept ? rx_cnt + ADDR_WIDTH'(1) : rx_cnt;
    err_nxt   = (mismatch && (err_cnt != ALL_ONES)) ? err_cnt + ADDR_WIDTH'(1) : err_cnt;
    reach     = accept && (rx_nxt == target);
    end_short = (state == CHECK) && !reach && bus.i_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_run) state_nxt = (bus.i_cnt == '0) ? DONE : CHECK;
      CHECK:   if (reach || end_short) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_idle = (state == IDLE);
    bus.o_busy = (state == CHECK);
    bus.o_done = (state == DONE);
  end

  // The verdict is written on the edge that enters DONE so it is valid alongside o_done;
  // a zero-count start enters DONE directly, hence its pass value is loaded at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target        <= '0;
      rx_cnt        <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      exp_val       <= '0;
      short_r       <= 1'b0;
      pass_r        <= 1'b0;
    end else if (start) begin
      target        <= bus.i_cnt;
      rx_cnt        <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      exp_val       <= '0;
      short_r       <= 1'b0;
      pass_r        <= (bus.i_cnt == '0);
    end else if (state == CHECK) begin
      rx_cnt  <= rx_nxt;
      err_cnt <= err_nxt;
      if (mismatch && (err_cnt == '0)) first_err_idx <= rx_cnt;
      if (accept) exp_val <= (exp_val == EXP_LAST) ? '0 : exp_val + DATA_WIDTH'(1);
      if (end_short) short_r <= 1'b1;
      if (reach || end_short)
        pass_r <= (err_nxt == '0) && !end_short && (rx_nxt == target);
    end
  end

  assign bus.o_pass          = pass_r;
  assign bus.o_short         = short_r;
  assign bus.o_rx_cnt        = rx_cnt;
  assign bus.o_err_cnt       = err_cnt;
  assign bus.o_first_err_idx = first_err_idx;

`ifdef BRAM_CHK_SUM_EN
  localparam int SUM_W = DATA_WIDTH + ADDR_WIDTH;
  logic [SUM_W-1:0] sum_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sum_r <= '0;
    else if (start)  sum_r <= '0;
    else if (accept) sum_r <= sum_r + SUM_W'(bus.i_data);
  end

  assign bus.o_sum = sum_r;
`endif

endmodule

// File: tb/tb_bram_rd_checker.sv
// Self-checking bench for bram_rd_checker: directed scenarios plus randomized runs
// compared against a list-based model of the expected-pattern rules.
module tb_bram_rd_checker;
  localparam int DW   = 16;
  localparam int AW   = 7;
  localparam int MODV = 100;
  localparam int ONES = (1 << AW) - 1;

  typedef struct {
    int rx;
    int err;
    int first;
    int short_f;
    int pass;
    int sum;
    int done_ok;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_rd_checker_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_rd_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MOD(MODV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [DW-1:0] stim_q[$];

  task automatic idle_inputs();
    bus.i_run = 1'b0; bus.i_cnt = '0; bus.i_valid = 1'b0; bus.i_data = '0; bus.i_done = 1'b0;
  endtask

  // Reference: word k should equal k mod MODV; fewer words than cnt means the run was cut short.
  function automatic res_t model(input int cnt);
    res_t r;
    r.rx = stim_q.size(); r.err = 0; r.first = ONES; r.sum = 0; r.done_ok = 1;
    foreach (stim_q[k]) begin
      r.sum += int'(stim_q[k]);
      if (int'(stim_q[k]) != (k % MODV)) begin
        if (r.err == 0) r.first = k;
        if (r.err < ONES) r.err++;
      end
    end
    r.short_f = (stim_q.size() < cnt) ? 1 : 0;
    r.pass    = (r.err == 0 && r.short_f == 0 && r.rx == cnt) ? 1 : 0;
    return r;
  endfunction

  // Drives one run from stim_q, ending with an i_done cycle when stim_q is shorter than cnt.
  // done_ok collects the handshake rules: busy during the run, one done pulse right after the
  // final input edge, then idle.
  task automatic run_stream(input int cnt, input bit gaps, input bit junk, output res_t obs);
    obs.done_ok = 1;
    bus.i_run = 1'b1; bus.i_cnt = AW'(cnt); bus.i_valid = junk; bus.i_data = 16'hBEEF;
    @(posedge clk); #1;
    bus.i_run = 1'b0; bus.i_valid = 1'b0;
    if (cnt != 0) begin
      if (bus.o_busy !== 1'b1) obs.done_ok = 0;
      foreach (stim_q[k]) begin
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            bus.i_valid = 1'b0; bus.i_data = DW'($urandom);
            @(posedge clk); #1;
            if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) obs.done_ok = 0;
          end
        end
        bus.i_valid = 1'b1; bus.i_data = stim_q[k];
        @(posedge clk); #1;
        if ((k < cnt - 1) && (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0)) obs.done_ok = 0;
      end
      bus.i_valid = 1'b0;
      if (stim_q.size() < cnt) begin
        bus.i_done = 1'b1;
        @(posedge clk); #1;
        bus.i_done = 1'b0;
      end
    end
    if (bus.o_done !== 1'b1) obs.done_ok = 0;
    obs.rx      = int'(bus.o_rx_cnt);
    obs.err     = int'(bus.o_err_cnt);
    obs.first   = int'(bus.o_first_err_idx);
    obs.short_f = int'(bus.o_short);
    obs.pass    = int'(bus.o_pass);
`ifdef BRAM_CHK_SUM_EN
    obs.sum     = int'(bus.o_sum);
`else
    obs.sum     = 0;
`endif
    @(posedge clk); #1;
    if (bus.o_done !== 1'b0 || bus.o_idle !== 1'b1) obs.done_ok = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (bus.o_idle !== 1'b1) begin mismatched++; $display("FAIL reset_idle: got %b want 1", bus.o_idle); end
    compared++; if (bus.o_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    compared++; if (bus.o_done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    compared++; if (bus.o_pass !== 1'b0) begin mismatched++; $display("FAIL reset_pass: got %b want 0", bus.o_pass); end
    compared++; if (bus.o_short !== 1'b0) begin mismatched++; $display("FAIL reset_short: got %b want 0", bus.o_short); end
    compared++; if (bus.o_rx_cnt !== 7'd0) begin mismatched++; $display("FAIL reset_rx: got %0d want 0", bus.o_rx_cnt); end
    compared++; if (bus.o_err_cnt !== 7'd0) begin mismatched++; $display("FAIL reset_err: got %0d want 0", bus.o_err_cnt); end
    compared++; if (bus.o_first_err_idx !== 7'd127) begin mismatched++; $display("FAIL reset_first: got %0d want 127", bus.o_first_err_idx); end
`ifdef BRAM_CHK_SUM_EN
    compared++; if (bus.o_sum !== '0) begin mismatched++; $display("FAIL reset_sum: got %0d want 0", bus.o_sum); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_run();
    res_t obs, exp;
    stim_q.delete();
    for (int k = 0; k < 100; k++) stim_q.push_back(DW'(k));
    exp = model(100);
    run_stream(100, 1'b0, 1'b0, obs);
    compared++; if (obs.done_ok !== 1) begin mismatched++; $display("FAIL full_handshake: got %0d want 1", obs.done_ok); end
    compared++; if (obs.pass !== 1) begin mismatched++; $display("FAIL full_pass: got %0d want 1", obs.pass); end
    compared++; if (obs.rx !== 100) begin mismatched++; $display("FAIL full_rx: got %0d want 100", obs.rx); end
    compared++; if (obs.err !== 0) begin mismatched++; $display("FAIL full_err: got %0d want 0", obs.err); end
    compared++; if (obs.first !== 127) begin mismatched++; $display("FAIL full_first: got %0d want 127", obs.first); end
`ifdef BRAM_CHK_SUM_EN
    compared++; if (obs.sum !== exp.sum) begin mismatched++; $display("FAIL full_sum: got %0d want %0d", obs.sum, exp.sum); end
`endif
  endtask

  task automatic test_wrap();
    res_t obs, exp;
    stim_q.delete();
    for (int k = 0; k < 127; k++) stim_q.push_back(DW'(k % MODV));
    exp = model(127);
    run_stream(127, 1'b0, 1'b0, obs);
    compared++; if (obs.done_ok !== 1) begin mismatched++; $display("FAIL wrap_handshake: got %0d want 1", obs.done_ok); end
    compared++; if (obs.pass !== exp.pass) begin mismatched++; $display("FAIL wrap_pass: got %0d want %0d", obs.pass, exp.pass); end
    compared++; if (obs.rx !== 127) begin mismatched++; $display("FAIL wrap_rx: got %0d want 127", obs.rx); end
`ifdef BRAM_CHK_SUM_EN
    compared++; if (obs.sum !== 5301) begin mismatched++; $display("FAIL wrap_sum: got %0d want 5301", obs.sum); end
`endif
  endtask

  task automatic test_corrupt();
    res_t obs, exp;
    stim_q.delete();
    for (int k = 0; k < 100; k++) stim_q.push_back(DW'(k));
    stim_q[37] = 16'hFFFF;
    stim_q[80] = 16'h0000;
    exp = model(100);
    run_stream(100, 1'b0, 1'b0, obs);
    compared++; if (obs.done_ok !== 1) begin mismatched++; $display("FAIL corrupt_handshake: got %0d want 1", obs.done_ok); end
    compared++; if (obs.err !== exp.err) begin mismatched++; $display("FAIL corrupt_err: got %0d want %0d", obs.err, exp.err); end
    compared++; if (obs.first !== exp.first) begin mismatched++; $display("FAIL corrupt_first: got %0d want %0d", obs.first, exp.first); end
    compared++; if (obs.pass !== 0) begin mismatched++; $display("FAIL corrupt_pass: got %0d want 0", obs.pass); end
  endtask

  task automatic test_zero();
    res_t obs;
    stim_q.delete();
    run_stream(0, 1'b0, 1'b0, obs);
    compared++; if (obs.done_ok !== 1) begin mismatched++; $display("FAIL zero_handshake: got %0d want 1", obs.done_ok); end
    compared++; if (obs.pass !== 1) begin mismatched++; $display("FAIL zero_pass: got %0d want 1", obs.pass); end
    compared++; if (obs.rx !== 0) begin mismatched++; $display("FAIL zero_rx: got %0d want 0", obs.rx); end
  endtask

  task automatic test_short();
    res_t obs;
    stim_q.delete();
    for (int k = 0; k < 50; k++) stim_q.push_back(DW'(k));
    run_stream(100, 1'b0, 1'b0, obs);
    compared++; if (obs.done_ok !== 1) begin mismatched++; $display("FAIL short_handshake: got %0d want 1", obs.done_ok); end
    compared++; if (obs.short_f !== 1) begin mismatched++; $display("FAIL short_flag: got %0d want 1", obs.short_f); end
    compared++; if (obs.rx !== 50) begin mismatched++; $display("FAIL short_rx: got %0d want 50", obs.rx); end
    compared++; if (obs.pass !== 0) begin mismatched++; $display("FAIL short_pass: got %0d want 0", obs.pass); end
  endtask

  task automatic test_hold();
    bus.i_run = 1'b0;
    repeat (3) begin
      bus.i_valid = 1'b1; bus.i_done = 1'b1; bus.i_data = DW'($urandom);
      @(posedge clk); #1;
    end
    idle_inputs();
    compared++; if (bus.o_rx_cnt !== 7'd50) begin mismatched++; $display("FAIL hold_rx: got %0d want 50", bus.o_rx_cnt); end
    compared++; if (bus.o_short !== 1'b1) begin mismatched++; $display("FAIL hold_short: got %b want 1", bus.o_short); end
    compared++; if (bus.o_idle !== 1'b1) begin mismatched++; $display("FAIL hold_idle: got %b want 1", bus.o_idle); end
  endtask

  task automatic test_random();
    res_t obs, exp;
    for (int it = 0; it < 10; it++) begin
      int cnt, nw;
      bit cut;
      cnt = (it == 0) ? 127 : int'($urandom_range(1, 127));
      cut = (it != 0) && ($urandom_range(0, 3) == 0);
      nw  = cut ? int'($urandom_range(0, cnt - 1)) : cnt;
      stim_q.delete();
      for (int k = 0; k < nw; k++) begin
        if (it == 0)                        stim_q.push_back(DW'((k % MODV) + 1));
        else if ($urandom_range(0, 7) == 0) stim_q.push_back(DW'($urandom));
        else                                stim_q.push_back(DW'(k % MODV));
      end
      exp = model(cnt);
      run_stream(cnt, 1'b1, 1'b1, obs);
      compared++; if (obs.done_ok !== 1) begin mismatched++; $display("FAIL rnd%0d_handshake: got %0d want 1", it, obs.done_ok); end
      compared++; if (obs.rx !== exp.rx) begin mismatched++; $display("FAIL rnd%0d_rx: got %0d want %0d", it, obs.rx, exp.rx); end
      compared++; if (obs.err !== exp.err) begin mismatched++; $display("FAIL rnd%0d_err: got %0d want %0d", it, obs.err, exp.err); end
      compared++; if (obs.first !== exp.first) begin mismatched++; $display("FAIL rnd%0d_first: got %0d want %0d", it, obs.first, exp.first); end
      compared++; if (obs.short_f !== exp.short_f) begin mismatched++; $display("FAIL rnd%0d_short: got %0d want %0d", it, obs.short_f, exp.short_f); end
      compared++; if (obs.pass !== exp.pass) begin mismatched++; $display("FAIL rnd%0d_pass: got %0d want %0d", it, obs.pass, exp.pass); end
`ifdef BRAM_CHK_SUM_EN
      compared++; if (obs.sum !== exp.sum) begin mismatched++; $display("FAIL rnd%0d_sum: got %0d want %0d", it, obs.sum, exp.sum); end
`endif
    end
  endtask

  task automatic test_ignored_and_reset();
    bit saw_done;
    saw_done = 1'b0;
    bus.i_run = 1'b1; bus.i_cnt = 7'd100;
    @(posedge clk); #1;
    bus.i_run = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin bus.i_run = 1'b1; bus.i_cnt = 7'd5; end
      bus.i_valid = 1'b1; bus.i_data = DW'(k);
      @(posedge clk); #1;
      bus.i_run = 1'b0;
      if (bus.o_done !== 1'b0) saw_done = 1'b1;
    end
    bus.i_valid = 1'b0;
    compared++; if (bus.o_rx_cnt !== 7'd20) begin mismatched++; $display("FAIL midrun_rx: got %0d want 20", bus.o_rx_cnt); end
    compared++; if (bus.o_busy !== 1'b1) begin mismatched++; $display("FAIL midrun_busy: got %b want 1", bus.o_busy); end
    compared++; if (bus.o_err_cnt !== 7'd0) begin mismatched++; $display("FAIL midrun_err: got %0d want 0", bus.o_err_cnt); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (bus.o_idle !== 1'b1) begin mismatched++; $display("FAIL abort_idle: got %b want 1", bus.o_idle); end
    compared++; if (bus.o_busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b want 0", bus.o_busy); end
    compared++; if (bus.o_rx_cnt !== 7'd0) begin mismatched++; $display("FAIL abort_rx: got %0d want 0", bus.o_rx_cnt); end
    compared++; if (bus.o_first_err_idx !== 7'd127) begin mismatched++; $display("FAIL abort_first: got %0d want 127", bus.o_first_err_idx); end
`ifdef BRAM_CHK_SUM_EN
    compared++; if (bus.o_sum !== '0) begin mismatched++; $display("FAIL abort_sum: got %0d want 0", bus.o_sum); end
`endif
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.o_done !== 1'b0) saw_done = 1'b1;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.o_done !== 1'b0) saw_done = 1'b1;
    end
    compared++; if (saw_done !== 1'b0) begin mismatched++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
    compared++; if (bus.o_pass !== 1'b0) begin mismatched++; $display("FAIL abort_pass: got %b want 0", bus.o_pass); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_full_run();
    test_wrap();
    test_corrupt();
    test_zero();
    test_short();
    test_hold();
    test_random();
    test_ignored_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
